// File: rtl/mmio_fabric.sv
// mmio_fabric: routes CPU IO accesses to NUM_DEV valid/ready devices with byte steering, write-only masking and timeouts
module mmio_fabric #(
  parameter int NUM_DEV = 4,
  parameter int SEL_LSB = 20,
  parameter int SEL_W = 6,
  parameter int DEV_ADDR_W = 16,
  parameter logic [NUM_DEV-1:0] WRITE_ONLY = NUM_DEV'(1),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    main_clk,
  input  logic                    main_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [15:0]             req_wdata,
  input  logic                    req_write,
  input  logic                    req_byte,
  output logic                    rsp_valid,
  output logic [15:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_DEV-1:0]      dev_req_valid,
  input  logic [NUM_DEV-1:0]      dev_req_ready,
  output logic [DEV_ADDR_W-1:0]   dev_addr,
  output logic [15:0]             dev_wdata,
  output logic                    dev_write,
  output logic                    dev_byte,
  input  logic [NUM_DEV-1:0]      dev_rsp_valid,
  input  logic [16*NUM_DEV-1:0]   dev_rdata
);
  localparam int IW = NUM_DEV > 1 ? $clog2(NUM_DEV) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;
  state_t state_q;
  logic [IW-1:0] idx_q;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] rd_q, rsp_rdata_q, dev_wdata_q, sel_w, rd_fmt;
  logic err_q, rsp_err_q, rsp_valid_q, req_ready_q, dev_write_q, dev_byte_q;
  logic [NUM_DEV-1:0] dev_req_valid_q;
  logic [DEV_ADDR_W-1:0] dev_addr_q;
  logic [SEL_W-1:0] sel;
  logic sel_rdy, sel_rv, tmo, done, unused_addr;
  assign unused_addr = ^req_addr;
  always_comb begin
    sel = req_addr[SEL_LSB +: SEL_W];
    sel_rdy = 1'b0;
    sel_rv = 1'b0;
    sel_w = 16'h0;
    for (int i = 0; i < NUM_DEV; i++)
      if (int'(idx_q) == i) begin
        sel_rdy = dev_req_ready[i];
        sel_rv = dev_rsp_valid[i];
        sel_w = dev_rdata[16*i +: 16];
      end
    cnt_d = cnt_q + 32'd1;
    tmo = TIMEOUT != 0 && cnt_d == TIMEOUT;
    done = sel_rdy && (dev_write_q || sel_rv);
    rd_fmt = !dev_byte_q ? sel_w : dev_addr_q[0] ? {8'h0, sel_w[15:8]} : {8'h0, sel_w[7:0]};
  end
  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      dev_req_valid_q <= '0;
      dev_addr_q <= '0;
      dev_wdata_q <= '0;
      dev_write_q <= 1'b0;
      dev_byte_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          cnt_q <= '0;
          rd_q <= '0;
          err_q <= 1'b0;
          req_ready_q <= 1'b0;
          idx_q <= IW'(sel);
          dev_addr_q <= req_addr[DEV_ADDR_W-1:0];
          dev_wdata_q <= req_byte ? {2{req_wdata[7:0]}} : req_wdata;
          dev_write_q <= req_write;
          dev_byte_q <= req_byte;
          if (!req_addr[31] || int'(sel) >= NUM_DEV) begin
            err_q <= 1'b1;
            state_q <= RESP;
          end else if (!req_write && WRITE_ONLY[IW'(sel)]) state_q <= RESP;
          else begin
            dev_req_valid_q <= NUM_DEV'(1) << IW'(sel);
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_d;
          if (sel_rdy || tmo) dev_req_valid_q <= '0;
          if (done) begin
            if (!dev_write_q) rd_q <= rd_fmt;
            state_q <= RESP;
          end else if (tmo) begin
            err_q <= 1'b1;
            state_q <= RESP;
          end else if (sel_rdy) state_q <= WAIT_RSP;
        end
        WAIT_RSP: begin
          cnt_q <= cnt_d;
          if (sel_rv) begin
            rd_q <= rd_fmt;
            state_q <= RESP;
          end else if (tmo) begin
            err_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rd_q;
          rsp_err_q <= err_q;
          req_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign dev_req_valid = dev_req_valid_q;
  assign dev_addr = dev_addr_q;
  assign dev_wdata = dev_wdata_q;
  assign dev_write = dev_write_q;
  assign dev_byte = dev_byte_q;
endmodule
